// File: rtl/mysystem_pio_done_pkg.sv
// Shared constants for the mysystem PIO blocks: Avalon register word
// addresses and edge-type selector codes.
package mysystem_pio_done_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_UNUSED  = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/mysystem_pio_sync.sv
// Multi-flop synchroniser for a bus of asynchronous inputs; every stage
// resets to 0 so a freshly reset chain never presents stale data.
module mysystem_pio_sync #(
    parameter int DATA_WIDTH  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/mysystem_pio_done.sv
// Avalon-MM input PIO: synchronises the accelerator status lines, captures
// per-bit edges and raises a maskable level interrupt.
module mysystem_pio_done
    import mysystem_pio_done_pkg::*;
#(
    parameter int DATA_WIDTH  = 1,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    // Three bits so a depth-3 synchroniser (target 4) still saturates cleanly.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] w_sync_q;
    logic [DATA_WIDTH-1:0] r_sync_d;
    logic [2:0]            r_warm;
    logic [DATA_WIDTH-1:0] r_irq_mask;
    logic [DATA_WIDTH-1:0] r_edge_cap;
    logic [31:0]           r_readdata;
    logic                  w_armed;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    function automatic logic [DATA_WIDTH-1:0] f_edge(input logic [DATA_WIDTH-1:0] q,
                                                     input logic [DATA_WIDTH-1:0] d);
        case (EDGE_TYPE)
            EDGE_FALL: return ~q & d;
            EDGE_ANY:  return q ^ d;
            default:   return q & ~d;
        endcase
    endfunction

    mysystem_pio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (in_port),
        .o_q     (w_sync_q)
    );

    assign w_armed = (r_warm == WARM_DONE);
    assign w_wr    = chipselect & ~write_n;
    assign w_edge  = w_armed ? f_edge(w_sync_q, r_sync_d) : '0;
    assign w_clr   = (w_wr && address == PIO_ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;

    // Upper write-data bits have no register behind them.
    assign w_unused_wdata = &{1'b0, writedata};

    always_comb begin
        w_rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    w_rd_mux = 32'(w_sync_q);
            PIO_ADDR_IRQMASK: w_rd_mux = 32'(r_irq_mask);
            PIO_ADDR_EDGE:    w_rd_mux = 32'(r_edge_cap);
            default:          w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_d   <= '0;
            r_warm     <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            r_sync_d <= w_sync_q;
            if (!w_armed) begin
                r_warm <= r_warm + 3'd1;
            end
            if (w_wr && address == PIO_ADDR_IRQMASK) begin
                r_irq_mask <= writedata[DATA_WIDTH-1:0];
            end
            // A new edge overrides a same-cycle clear so no event is dropped.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_mysystem_pio_done.sv
// Bench for mysystem_pio_done: two configurations share one Avalon bus and are
// compared every cycle against an input-history reference model.
module tb_mysystem_pio_done;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  bus_addr;
    logic        bus_cs;
    logic        bus_wn;
    logic [31:0] bus_wd;
    logic [0:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mysystem_pio_done #(.DATA_WIDTH(1), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(bus_addr), .chipselect(bus_cs),
        .write_n(bus_wn), .writedata(bus_wd), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    mysystem_pio_done #(.DATA_WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(bus_addr), .chipselect(bus_cs),
        .write_n(bus_wn), .writedata(bus_wd), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    // Reference model: input sampled at edge k after reset release is hist[c][k];
    // the data register shows the input from SYNC_STAGES edges ago, and edges are
    // only recognised once the warmup of SYNC_STAGES+1 cycles has elapsed.
    int          cfg_w [2] = '{1, 4};
    int          cfg_et[2] = '{0, 2};
    int          cfg_s [2] = '{2, 3};
    int          n_edge[2];
    logic [31:0] hist  [2][8192];
    logic [31:0] m_cap [2];
    logic [31:0] m_mask[2];
    logic [31:0] m_rd  [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            n_edge[c] = 0;
            m_cap[c]  = '0;
            m_mask[c] = '0;
            m_rd[c]   = '0;
        end
    endtask

    task automatic model_edge(input int c, input logic [31:0] in_v);
        logic [31:0] wm, q, d, ev;
        int k;
        wm = (32'd1 << cfg_w[c]) - 32'd1;
        n_edge[c]++;
        k = n_edge[c];
        hist[c][k] = in_v & wm;
        q = (k - cfg_s[c] >= 1)     ? hist[c][k - cfg_s[c]]     : '0;
        d = (k - cfg_s[c] - 1 >= 1) ? hist[c][k - cfg_s[c] - 1] : '0;
        if (k >= cfg_s[c] + 2) begin
            case (cfg_et[c])
                0:       ev = q & ~d;
                1:       ev = ~q & d;
                default: ev = q ^ d;
            endcase
        end else begin
            ev = '0;
        end
        case (bus_addr)
            2'd0:    m_rd[c] = q;
            2'd2:    m_rd[c] = m_mask[c];
            2'd3:    m_rd[c] = m_cap[c];
            default: m_rd[c] = '0;
        endcase
        if (bus_cs && !bus_wn && bus_addr == 2'd3) m_cap[c] = m_cap[c] & ~bus_wd;
        m_cap[c] = (m_cap[c] | ev) & wm;
        if (bus_cs && !bus_wn && bus_addr == 2'd2) m_mask[c] = bus_wd & wm;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, {31'b0, in_a});
        model_edge(1, {28'b0, in_b});
        #1;
        chk("rd_a",  rd_a, m_rd[0]);
        chk("irq_a", {31'b0, irq_a}, {31'b0, |(m_cap[0] & m_mask[0])});
        chk("rd_b",  rd_b, m_rd[1]);
        chk("irq_b", {31'b0, irq_b}, {31'b0, |(m_cap[1] & m_mask[1])});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        bus_addr = a; bus_cs = 1'b1; bus_wn = 1'b0; bus_wd = wd;
        tick();
        bus_cs = 1'b0; bus_wn = 1'b1; bus_wd = '0;
    endtask

    initial begin
        reset_n  = 1'b0;
        bus_addr = 2'd3; bus_cs = 1'b0; bus_wn = 1'b1; bus_wd = '0;
        in_a     = 1'b1;
        in_b     = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_a", rd_a, 32'h0);
        chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
        reset_n = 1'b1;

        // Inputs already high at reset must not register as edges.
        ticks(10);
        chk("t1_cap_a", rd_a, 32'h0);
        chk("t1_irq_a", {31'b0, irq_a}, 32'h0);
        chk("t1_cap_b", rd_b, 32'h0);
        bus_addr = 2'd0;
        tick();
        chk("t1_data_a", rd_a, 32'h1);
        chk("t1_data_b", rd_b, 32'hF);

        // Rising edge with mask set, then W1C.
        in_a = 1'b0;
        ticks(5);
        bus_write(2'd2, 32'h1);
        bus_addr = 2'd3;
        in_a = 1'b1;
        ticks(2);
        chk("t2_irq_early", {31'b0, irq_a}, 32'h0);
        tick();
        chk("t2_irq_set", {31'b0, irq_a}, 32'h1);
        tick();
        chk("t2_cap_rd", rd_a, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("t2_irq_clr", {31'b0, irq_a}, 32'h0);

        // Masked capture, then unmask.
        bus_write(2'd2, 32'h0);
        bus_addr = 2'd3;
        in_a = 1'b0;
        ticks(4);
        in_a = 1'b1;
        ticks(4);
        chk("t3_irq_masked", {31'b0, irq_a}, 32'h0);
        chk("t3_cap_rd", rd_a, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("t3_irq_unmask", {31'b0, irq_a}, 32'h1);

        // Clear coinciding with a new edge: the edge must survive.
        bus_addr = 2'd3;
        in_a = 1'b0;
        ticks(4);
        in_a = 1'b1;
        ticks(2);
        bus_write(2'd3, 32'h1);
        chk("t4_irq_kept", {31'b0, irq_a}, 32'h1);
        bus_addr = 2'd3;
        tick();
        chk("t4_cap_kept", rd_a, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("t4_irq_clr", {31'b0, irq_a}, 32'h0);

        // Any-edge capture on the 4-bit instance.
        bus_write(2'd3, 32'hF);
        bus_addr = 2'd3;
        in_b = 4'h6;
        ticks(5);
        chk("t5_cap_b", rd_b, 32'h9);
        bus_write(2'd3, 32'h1);
        bus_addr = 2'd3;
        tick();
        chk("t5_w1c_b", rd_b, 32'h8);
        bus_addr = 2'd1;
        tick();
        chk("t5_addr1_b", rd_b, 32'h0);
        chk("t5_addr1_a", rd_a, 32'h0);

        // Asynchronous reset mid-run with an active interrupt.
        bus_addr = 2'd3;
        in_a = 1'b0;
        ticks(4);
        in_a = 1'b1;
        ticks(4);
        chk("t6_irq_before", {31'b0, irq_a}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_irq_a", {31'b0, irq_a}, 32'h0);
        chk("t6_irq_b", {31'b0, irq_b}, 32'h0);
        chk("t6_rd_a", rd_a, 32'h0);
        chk("t6_rd_b", rd_b, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) in_a = ~in_a;
            if ($urandom_range(0, 2) == 0) in_b = in_b ^ 4'($urandom);
            bus_addr = 2'($urandom);
            bus_cs   = 1'($urandom);
            bus_wn   = 1'($urandom);
            bus_wd   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
